// File: rtl/dram_wr_arbiter_pkg.sv
// Shared graphics types for the DDR write path: burst widths, arbiter states, burst payload.
package dram_wr_arbiter_pkg;

    localparam int unsigned ADDR_W  = 31;
    localparam int unsigned DATA_W  = 128;
    localparam int unsigned MASK_W  = 16;
    localparam int unsigned NUM_REQ = 2;

    localparam logic [MASK_W-1:0] MASK_NONE = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BEAT1 = 2'b01,
        BEAT2 = 2'b10
    } wr_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data0;
        logic [DATA_W-1:0] data1;
        logic [MASK_W-1:0] mask0;
        logic [MASK_W-1:0] mask1;
    } wr_burst_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant selection: round-robin on a last-granted pointer, or requester 0 fixed priority.
module rr_arb2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       grant_c,
    output logic       valid_c
);

    logic last_q;

    always_comb begin
        valid_c = |req;
        grant_c = 1'b0;
        if (FIXED_PRIO) begin
            grant_c = ~req[0];
        end else if (req == 2'b11) begin
            grant_c = ~last_q;
        end else begin
            grant_c = req[1];
        end
    end

    // Pointer starts at 1 so requester 0 wins the first contest after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (take && valid_c) begin
            last_q <= grant_c;
        end
    end

endmodule

// File: rtl/dram_wr_arbiter.sv
// Arbitrates two burst requesters onto the DDR address / write-data FIFOs, one 2-beat burst at a time.
module dram_wr_arbiter
    import dram_wr_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        rq_req,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq0_data0,
    input  logic [DATA_W-1:0] rq0_data1,
    input  logic [DATA_W-1:0] rq1_data0,
    input  logic [DATA_W-1:0] rq1_data1,
    input  logic [MASK_W-1:0] rq0_mask0,
    input  logic [MASK_W-1:0] rq0_mask1,
    input  logic [MASK_W-1:0] rq1_mask0,
    input  logic [MASK_W-1:0] rq1_mask1,
    output logic [1:0]        rq_ack,
    input  logic              af_full,
    input  logic              wdf_full,
    output logic [ADDR_W-1:0] af_addr_din,
    output logic              af_wr_en,
    output logic [DATA_W-1:0] wdf_din,
    output logic [MASK_W-1:0] wdf_mask_din,
    output logic              wdf_wr_en,
    output logic              arb_idle
);

    wr_state_e state_q;
    wr_state_e state_d;
    wr_burst_t burst_q;
    wr_burst_t sel_c;
    logic      grant_c;
    logic      valid_c;
    logic      take_c;

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (rq_req),
        .take    (take_c),
        .grant_c (grant_c),
        .valid_c (valid_c)
    );

    always_comb begin
        if (grant_c) begin
            sel_c = {rq1_addr, rq1_data0, rq1_data1, rq1_mask0, rq1_mask1};
        end else begin
            sel_c = {rq0_addr, rq0_data0, rq0_data1, rq0_mask0, rq0_mask1};
        end
    end

    // Next state and FIFO enables; requests only matter in IDLE.
    always_comb begin
        state_d   = state_q;
        af_wr_en  = 1'b0;
        wdf_wr_en = 1'b0;
        take_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_c) begin
                    take_c  = 1'b1;
                    state_d = BEAT1;
                end
            end
            BEAT1: begin
                if (!af_full && !wdf_full) begin
                    af_wr_en  = 1'b1;
                    wdf_wr_en = 1'b1;
                    state_d   = BEAT2;
                end
            end
            BEAT2: begin
                if (!wdf_full) begin
                    wdf_wr_en = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            af_wr_en  = 1'b0;
            wdf_wr_en = 1'b0;
            take_c    = 1'b0;
        end
    end

    // Address and data are left unreset; only the masks must read as "write nothing".
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rq_ack        <= 2'b00;
            burst_q.mask0 <= MASK_NONE;
            burst_q.mask1 <= MASK_NONE;
        end else begin
            state_q <= state_d;
            rq_ack  <= take_c ? (2'b01 << grant_c) : 2'b00;
            if (take_c) begin
                burst_q <= sel_c;
            end
        end
    end

    always_comb begin
        af_addr_din  = burst_q.addr;
        wdf_din      = (state_q == BEAT2) ? burst_q.data1 : burst_q.data0;
        wdf_mask_din = MASK_NONE;
        if (state_q == BEAT1) begin
            wdf_mask_din = burst_q.mask0;
        end else if (state_q == BEAT2) begin
            wdf_mask_din = burst_q.mask1;
        end
        arb_idle = (state_q == IDLE);
    end

endmodule

// File: tb/tb_dram_wr_arbiter.sv
// Bench for dram_wr_arbiter: round-robin and fixed-priority instances share one set of stimulus.
module tb_dram_wr_arbiter;
    import dram_wr_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic [1:0]        rq_req = 2'b00;
    logic [ADDR_W-1:0] rq0_addr = '0, rq1_addr = '0;
    logic [DATA_W-1:0] rq0_data0 = '0, rq0_data1 = '0, rq1_data0 = '0, rq1_data1 = '0;
    logic [MASK_W-1:0] rq0_mask0 = '0, rq0_mask1 = '0, rq1_mask0 = '0, rq1_mask1 = '0;
    logic              af_full = 1'b0, wdf_full = 1'b0;

    logic [1:0]        r_ack, f_ack;
    logic [ADDR_W-1:0] r_addr, f_addr;
    logic              r_af, f_af, r_wdf, f_wdf, r_idle, f_idle;
    logic [DATA_W-1:0] r_din, f_din;
    logic [MASK_W-1:0] r_mask, f_mask;

    int checks = 0;
    int errors = 0;

    dram_wr_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .rst(rst), .rq_req(rq_req),
        .rq0_addr(rq0_addr), .rq1_addr(rq1_addr),
        .rq0_data0(rq0_data0), .rq0_data1(rq0_data1), .rq1_data0(rq1_data0), .rq1_data1(rq1_data1),
        .rq0_mask0(rq0_mask0), .rq0_mask1(rq0_mask1), .rq1_mask0(rq1_mask0), .rq1_mask1(rq1_mask1),
        .rq_ack(r_ack), .af_full(af_full), .wdf_full(wdf_full),
        .af_addr_din(r_addr), .af_wr_en(r_af), .wdf_din(r_din), .wdf_mask_din(r_mask),
        .wdf_wr_en(r_wdf), .arb_idle(r_idle)
    );

    dram_wr_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst), .rq_req(rq_req),
        .rq0_addr(rq0_addr), .rq1_addr(rq1_addr),
        .rq0_data0(rq0_data0), .rq0_data1(rq0_data1), .rq1_data0(rq1_data0), .rq1_data1(rq1_data1),
        .rq0_mask0(rq0_mask0), .rq0_mask1(rq0_mask1), .rq1_mask0(rq1_mask0), .rq1_mask1(rq1_mask1),
        .rq_ack(f_ack), .af_full(af_full), .wdf_full(wdf_full),
        .af_addr_din(f_addr), .af_wr_en(f_af), .wdf_din(f_din), .wdf_mask_din(f_mask),
        .wdf_wr_en(f_wdf), .arb_idle(f_idle)
    );

    // Inputs change 2 time units after the rising edge, outputs are sampled 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        cyc();
        rst = 1'b1; rq_req = 2'b00; af_full = 1'b0; wdf_full = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic set_fixed_payloads();
        rq0_addr  = 31'h0000A00;                 rq1_addr  = 31'h0000B00;
        rq0_data0 = {4{32'hA0A0_0001}};          rq0_data1 = {4{32'hA0A0_0002}};
        rq1_data0 = {4{32'hB0B0_0001}};          rq1_data1 = {4{32'hB0B0_0002}};
        rq0_mask0 = 16'h00F0; rq0_mask1 = 16'h0F00; rq1_mask0 = 16'h000F; rq1_mask1 = 16'hF000;
    endtask

    task automatic test_reset();
        rst = 1'b1; rq_req = 2'b11;
        cyc(); cyc(); #1;
        checks++; if (r_ack !== 2'b00) begin errors++; $display("FAIL reset_ack got=%b exp=00", r_ack); end
        checks++; if (r_af !== 1'b0 || r_wdf !== 1'b0) begin errors++; $display("FAIL reset_en got=%b%b exp=00", r_af, r_wdf); end
        checks++; if (r_idle !== 1'b1 || f_idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b%b exp=11", r_idle, f_idle); end
        checks++; if (r_mask !== 16'hFFFF) begin errors++; $display("FAIL reset_mask got=%h exp=ffff", r_mask); end
        rst = 1'b0; rq_req = 2'b00;
    endtask

    task automatic test_single();
        set_fixed_payloads();
        cyc(); rq_req = 2'b01; rq0_addr = 31'h0000100; #1;
        checks++; if (r_idle !== 1'b1 || r_af !== 1'b0 || r_wdf !== 1'b0) begin errors++; $display("FAIL single_c0 got idle=%b af=%b wdf=%b exp 1,0,0", r_idle, r_af, r_wdf); end
        cyc(); rq_req = 2'b00; #1;
        checks++; if (r_ack !== 2'b01) begin errors++; $display("FAIL single_ack got=%b exp=01", r_ack); end
        checks++; if (r_af !== 1'b1 || r_addr !== 31'h0000100) begin errors++; $display("FAIL single_af got en=%b addr=%h exp 1,0000100", r_af, r_addr); end
        checks++; if (r_wdf !== 1'b1 || r_din !== {4{32'hA0A0_0001}} || r_mask !== 16'h00F0) begin errors++; $display("FAIL single_beat1 got en=%b din=%h mask=%h", r_wdf, r_din, r_mask); end
        checks++; if (r_idle !== 1'b0) begin errors++; $display("FAIL single_busy got=%b exp=0", r_idle); end
        cyc(); #1;
        checks++; if (r_ack !== 2'b00 || r_af !== 1'b0) begin errors++; $display("FAIL single_c2 got ack=%b af=%b exp 00,0", r_ack, r_af); end
        checks++; if (r_wdf !== 1'b1 || r_din !== {4{32'hA0A0_0002}} || r_mask !== 16'h0F00) begin errors++; $display("FAIL single_beat2 got en=%b din=%h mask=%h", r_wdf, r_din, r_mask); end
        cyc(); #1;
        checks++; if (r_idle !== 1'b1 || r_wdf !== 1'b0 || r_mask !== 16'hFFFF) begin errors++; $display("FAIL single_c3 got idle=%b wdf=%b mask=%h", r_idle, r_wdf, r_mask); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_rr;
        apply_reset();
        set_fixed_payloads();
        cyc(); rq_req = 2'b11;
        for (int c = 1; c <= 12; c++) begin
            cyc(); #1;
            if (c % 3 == 1) begin
                exp_rr = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
                checks++; if (r_ack !== exp_rr) begin errors++; $display("FAIL rr_grant c%0d got=%b exp=%b", c, r_ack, exp_rr); end
                checks++; if (r_af !== 1'b1 || r_addr !== (exp_rr[1] ? 31'h0000B00 : 31'h0000A00)) begin errors++; $display("FAIL rr_addr c%0d got en=%b addr=%h", c, r_af, r_addr); end
                checks++; if (f_ack !== 2'b01 || f_addr !== 31'h0000A00) begin errors++; $display("FAIL fp_grant c%0d got ack=%b addr=%h exp 01,0000a00", c, f_ack, f_addr); end
            end else begin
                checks++; if (r_ack !== 2'b00 || f_ack !== 2'b00) begin errors++; $display("FAIL b2b_noack c%0d got=%b/%b exp=00", c, r_ack, f_ack); end
            end
        end
        checks++; if (r_idle !== 1'b1) begin errors++; $display("FAIL b2b_idle12 got=%b exp=1", r_idle); end
        rq_req = 2'b10;
        cyc(); #1;
        checks++; if (f_ack !== 2'b10 || r_ack !== 2'b10) begin errors++; $display("FAIL req1_only got=%b/%b exp=10", r_ack, f_ack); end
        rq_req = 2'b00;
        repeat (3) cyc();
    endtask

    task automatic test_full_stall();
        apply_reset();
        set_fixed_payloads();
        cyc(); rq_req = 2'b01; rq0_addr = 31'h0000200;
        cyc(); rq_req = 2'b00; af_full = 1'b1; #1;
        checks++; if (r_ack !== 2'b01) begin errors++; $display("FAIL stall_ack got=%b exp=01", r_ack); end
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) begin cyc(); #1; end
            checks++; if (r_af !== 1'b0 || r_wdf !== 1'b0 || r_idle !== 1'b0) begin errors++; $display("FAIL stall_af c%0d got af=%b wdf=%b idle=%b", c, r_af, r_wdf, r_idle); end
        end
        cyc(); af_full = 1'b0; #1;
        checks++; if (r_af !== 1'b1 || r_wdf !== 1'b1 || r_addr !== 31'h0000200) begin errors++; $display("FAIL stall_beat1 got af=%b wdf=%b addr=%h", r_af, r_wdf, r_addr); end
        for (int c = 7; c <= 8; c++) begin
            cyc(); wdf_full = 1'b1; #1;
            checks++; if (r_wdf !== 1'b0 || r_af !== 1'b0) begin errors++; $display("FAIL stall_wdf c%0d got af=%b wdf=%b exp 0,0", c, r_af, r_wdf); end
        end
        cyc(); wdf_full = 1'b0; #1;
        checks++; if (r_wdf !== 1'b1 || r_din !== {4{32'hA0A0_0002}}) begin errors++; $display("FAIL stall_beat2 got en=%b din=%h", r_wdf, r_din); end
        cyc(); #1;
        checks++; if (r_idle !== 1'b1) begin errors++; $display("FAIL stall_done got=%b exp=1", r_idle); end
    endtask

    task automatic test_reset_mid_burst();
        cyc(); rq_req = 2'b01;
        cyc(); rq_req = 2'b00; #1;
        checks++; if (r_af !== 1'b1) begin errors++; $display("FAIL midrst_beat1 got=%b exp=1", r_af); end
        cyc(); rst = 1'b1; rq_req = 2'b11; #1;
        checks++; if (r_wdf !== 1'b0 || r_af !== 1'b0) begin errors++; $display("FAIL midrst_nowrite got af=%b wdf=%b exp 0,0", r_af, r_wdf); end
        cyc(); rst = 1'b0; #1;
        checks++; if (r_idle !== 1'b1 || r_ack !== 2'b00 || r_wdf !== 1'b0) begin errors++; $display("FAIL midrst_idle got idle=%b ack=%b wdf=%b", r_idle, r_ack, r_wdf); end
        cyc(); rq_req = 2'b00; #1;
        checks++; if (r_ack !== 2'b01) begin errors++; $display("FAIL midrst_grant got=%b exp=01", r_ack); end
        repeat (3) cyc();
    endtask

    // Transaction-level reference: a burst owes two beats; beat 1 needs both FIFOs free, beat 2 only wdf.
    task automatic test_random();
        localparam int N = 3000;
        int        beats[2], af_cnt[2], wdf_cnt[2], lost[2];
        logic      last[2];
        logic [1:0] ackn[2];
        wr_burst_t bur[2], pay[2];
        logic [1:0] want, prev_ack, cur_ack, a_ack;
        logic      drain, exp_af, exp_wdf, a_af, a_wdf, a_idle, w;
        logic [ADDR_W-1:0] a_addr;
        logic [DATA_W-1:0] a_din;
        logic [MASK_W-1:0] a_mask;
        apply_reset();
        for (int m = 0; m < 2; m++) begin
            beats[m] = 0; last[m] = 1'b1; ackn[m] = 2'b00; af_cnt[m] = 0; wdf_cnt[m] = 0; lost[m] = 0;
            bur[m] = '0;
        end
        for (int k = 0; k < 2; k++) pay[k] = {31'($urandom), {$urandom, $urandom, $urandom, $urandom},
                                              {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), 16'($urandom)};
        want = 2'b00; prev_ack = 2'b00;
        for (int i = 0; i < N; i++) begin
            cyc();
            for (int k = 0; k < 2; k++) begin
                if (prev_ack[k]) begin
                    pay[k] = {31'($urandom), {$urandom, $urandom, $urandom, $urandom},
                              {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), 16'($urandom)};
                    want[k] = ($urandom_range(3) != 0);
                end else if (!want[k]) begin
                    want[k] = 1'($urandom_range(1));
                end
            end
            drain    = (i >= N - 20);
            rst      = !drain && ($urandom_range(99) == 0);
            af_full  = !drain && ($urandom_range(3) == 0);
            wdf_full = !drain && ($urandom_range(3) == 0);
            rq_req   = drain ? 2'b00 : want;
            {rq0_addr, rq0_data0, rq0_data1, rq0_mask0, rq0_mask1} = pay[0];
            {rq1_addr, rq1_data0, rq1_data1, rq1_mask0, rq1_mask1} = pay[1];
            #1;
            cur_ack = ackn[0];
            for (int m = 0; m < 2; m++) begin
                a_ack  = (m == 0) ? r_ack  : f_ack;
                a_af   = (m == 0) ? r_af   : f_af;
                a_wdf  = (m == 0) ? r_wdf  : f_wdf;
                a_idle = (m == 0) ? r_idle : f_idle;
                a_addr = (m == 0) ? r_addr : f_addr;
                a_din  = (m == 0) ? r_din  : f_din;
                a_mask = (m == 0) ? r_mask : f_mask;
                exp_af  = (beats[m] == 2) && !af_full && !wdf_full && !rst;
                exp_wdf = (((beats[m] == 2) && !af_full && !wdf_full) || ((beats[m] == 1) && !wdf_full)) && !rst;
                checks++; if (a_ack !== ackn[m]) begin errors++; $display("FAIL rand_ack[%0d] cyc%0d got=%b exp=%b", m, i, a_ack, ackn[m]); end
                checks++; if (a_af !== exp_af || a_wdf !== exp_wdf) begin errors++; $display("FAIL rand_en[%0d] cyc%0d got=%b%b exp=%b%b", m, i, a_af, a_wdf, exp_af, exp_wdf); end
                checks++; if (a_idle !== (beats[m] == 0)) begin errors++; $display("FAIL rand_idle[%0d] cyc%0d got=%b exp=%b", m, i, a_idle, beats[m] == 0); end
                if (exp_af) begin
                    checks++; if (a_addr !== bur[m].addr || a_din !== bur[m].data0 || a_mask !== bur[m].mask0) begin errors++; $display("FAIL rand_beat1[%0d] cyc%0d got addr=%h mask=%h exp addr=%h mask=%h", m, i, a_addr, a_mask, bur[m].addr, bur[m].mask0); end
                end else if (exp_wdf) begin
                    checks++; if (a_din !== bur[m].data1 || a_mask !== bur[m].mask1) begin errors++; $display("FAIL rand_beat2[%0d] cyc%0d got mask=%h exp mask=%h", m, i, a_mask, bur[m].mask1); end
                end else if (beats[m] == 0) begin
                    checks++; if (a_mask !== 16'hFFFF) begin errors++; $display("FAIL rand_idlemask[%0d] cyc%0d got=%h exp=ffff", m, i, a_mask); end
                end
                af_cnt[m]  += int'(a_af);
                wdf_cnt[m] += int'(a_wdf);
                ackn[m] = 2'b00;
                if (rst) begin
                    if (beats[m] == 1) lost[m]++;
                    beats[m] = 0; last[m] = 1'b1;
                end else if (beats[m] == 0 && rq_req != 2'b00) begin
                    if (rq_req == 2'b11) w = (m == 1) ? 1'b0 : ~last[m];
                    else                 w = rq_req[1];
                    bur[m] = pay[w]; beats[m] = 2; last[m] = w; ackn[m] = w ? 2'b10 : 2'b01;
                end else if (exp_wdf) begin
                    beats[m] = beats[m] - 1;
                end
            end
            prev_ack = cur_ack;
        end
        for (int m = 0; m < 2; m++) begin
            checks++; if (af_cnt[m] * 2 != wdf_cnt[m] + lost[m]) begin errors++; $display("FAIL rand_balance[%0d] got af=%0d wdf=%0d lost=%0d", m, af_cnt[m], wdf_cnt[m], lost[m]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_stall();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_wr_arbiter.md
DRAM_WR_ARBITER -- requirements
Module: dram_wr_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0: 0 = round-robin between requesters; 1 = requester 0 always wins.
REQ-002 clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 rq_req[1:0]  in  2  per-requester burst request (bit 0 = LineEngine, bit 1 = frame filler).
REQ-005 rq0_addr, rq1_addr  in  31 each  DDR burst address, af_addr_din format.
REQ-006 rq0_data0, rq0_data1, rq1_data0, rq1_data1  in  128 each  first and second write-data beats.
REQ-007 rq0_mask0, rq0_mask1, rq1_mask0, rq1_mask1  in  16 each  byte masks for the two beats, 1 = byte not written.
REQ-008 rq_ack[1:0]  out  2  one-cycle pulse: that requester's payload has been captured.
REQ-009 af_full, wdf_full  in  1 each  DDR address and write-data FIFO full flags.
REQ-010 af_addr_din  out  31; af_wr_en  out  1  address FIFO write port.
REQ-011 wdf_din  out  128; wdf_mask_din  out  16; wdf_wr_en  out  1  write-data FIFO write port.
REQ-012 arb_idle  out  1  high when state is IDLE and no burst is pending; used to gate frame-base swaps.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BEAT1, BEAT2.
REQ-014 In IDLE with any rq_req bit high, the grant SHALL be chosen, the winner's addr/data0/data1/mask0/mask1 latched, the owner recorded, and the state SHALL move to BEAT1 on the same edge.
REQ-015 rq_ack[owner] SHALL be registered high for exactly the first cycle spent in BEAT1; the requester may change its payload and SHALL drop rq_req from the following cycle on.
REQ-016 rq_req SHALL be ignored in BEAT1 and BEAT2; a request still high on return to IDLE is a new request.
REQ-017 Round-robin: when both request in IDLE, the winner is the requester not granted most recently; the last-granted pointer resets to 1, so requester 0 wins the first contest.
REQ-018 FIXED_PRIO=1: requester 0 SHALL win every contest; requester 1 is granted only when rq_req[0] is low.
REQ-019 BEAT1: when af_full=0 and wdf_full=0, af_wr_en=wdf_wr_en=1 for that cycle with the latched addr, data0 and mask0, and the state moves to BEAT2; otherwise both enables are 0 and the state holds.
REQ-020 BEAT2: when wdf_full=0, wdf_wr_en=1 with the latched data1 and mask1, af_wr_en=0, and the state moves to IDLE; otherwise the state holds with both enables 0.
REQ-021 af_wr_en and wdf_wr_en SHALL be combinational functions of state and the full flags only, with no dependence on rq_req.
REQ-022 The address FIFO SHALL receive exactly one entry and the write-data FIFO exactly two entries per burst, in that order, never interleaved across requesters.
REQ-023 Minimum burst occupancy SHALL be 3 cycles (IDLE, BEAT1, BEAT2), giving back-to-back throughput of one burst per 3 cycles with the FIFOs not full.
REQ-024 af_addr_din, wdf_din and wdf_mask_din SHALL be driven from the latched payload in every state; the value is don't-care when the enables are 0, and the mask SHALL read 16'hFFFF in IDLE.
REQ-025 arb_idle SHALL be 1 in IDLE and 0 in BEAT1 and BEAT2.

Reset
REQ-026 On rst the state SHALL go to IDLE, rq_ack=0, the last-granted pointer=1, and the latched mask=16'hFFFF; the latched addr and data need not be reset.
REQ-027 A rst asserted mid-burst SHALL abandon the burst with no further FIFO writes from the next cycle; a half-written burst is accepted, since the DDR FIFOs are reset by the same rst.
REQ-028 In the cycle rst is high, af_wr_en and wdf_wr_en SHALL be 0.

Structure
REQ-029 State encodings (IDLE=2'b00, BEAT1=2'b01, BEAT2=2'b10), the 31-bit address width and the 128/16 data/mask widths SHALL live in the shared graphics package used by the line and fill engines.
REQ-030 The grant logic (2-way round-robin or fixed priority plus pointer) SHALL be one sub-module, rr_arb2; the FSM and payload latch stay in dram_wr_arbiter.

Verification
REQ-031 rq_req=01, addr=0x0000100, FIFOs never full -> ack0 in cycle 1; af write 0x0000100 plus wdf data0 in cycle 1; wdf data1 in cycle 2; arb_idle back to 1 in cycle 3.
REQ-032 rq_req=11 held for 4 bursts, round-robin -> grant order 0,1,0,1; one ack per burst; 12 cycles total.
REQ-033 Same stimulus with FIXED_PRIO=1 -> all four grants go to requester 0; requester 1 is granted only after rq_req[0] drops.
REQ-034 af_full=1 for 5 cycles at BEAT1 entry -> no enables during those 5 cycles; BEAT1 write in cycle 6; wdf_full=1 for 2 cycles at BEAT2 -> data1 written 2 cycles late.
REQ-035 rst pulsed in the BEAT2 cycle -> no wdf write that cycle; IDLE next cycle; the next contest with rq_req=11 grants requester 0.
REQ-036 Scoreboard over all runs: af writes × 2 == wdf writes; each af write is followed by exactly two wdf writes from the same owner.
